pipe_stage_chain: RTL and testbench

- Parametrised multi-stage pipeline register chain with per-stage valid bits and a valid/ready handshake on both ends.
- Supports backpressure, bubble collapsing and a synchronous flush.
- Sits between processor stages, and between the datapath and memory/peripheral interfaces, wherever a plain stage register cannot absorb stalls.
- Provides an occupancy count for hazard and drain logic.

---
 rtl/pipe_stage_chain.sv | 84 ++++++++
 tb/tb_pipe_stage_chain.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// ============================================================================
//  Module   : pipe_stage_chain
//  Purpose  : Multi-stage valid/ready register chain with bubble collapsing,
//             synchronous flush and an occupancy count.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_chain #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy
);

  logic [DEPTH-1:0]            r_v;
  logic [DEPTH-1:0][WIDTH-1:0] r_data;
  logic [DEPTH-1:0]            w_adv;
  logic [DEPTH-1:0]            w_src_v;
  logic [DEPTH-1:0][WIDTH-1:0] w_src_d;
  logic [CNT_W-1:0]            w_occ;

  // A stage may advance when it is empty or the stage ahead of it advances,
  // which lets bubbles close even while the output is stalled.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == DEPTH - 1) begin : g_tail
      assign w_adv[k] = !r_v[k] | out_ready;
    end else begin : g_mid
      assign w_adv[k] = !r_v[k] | w_adv[k+1];
    end

    if (k == 0) begin : g_head
      assign w_src_v[k] = in_valid;
      assign w_src_d[k] = in_data;
    end else begin : g_body
      assign w_src_v[k] = r_v[k-1];
      assign w_src_d[k] = r_data[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v    <= '0;
      r_data <= '0;
    end else if (flush) begin
      r_v    <= '0;
      r_data <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_adv[k]) begin
          r_v[k] <= w_src_v[k];
          if (w_src_v[k]) begin
            r_data[k] <= w_src_d[k];
          end
        end
      end
    end
  end

  always_comb begin
    w_occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_occ = w_occ + CNT_W'(r_v[k]);
    end
  end

  assign in_ready  = w_adv[0] & !flush;
  assign out_valid = r_v[DEPTH-1] & !flush;
  assign out_data  = r_data[DEPTH-1];
  assign occupancy = w_occ;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
// ============================================================================
//  Module   : tb_pipe_stage_chain
//  Purpose  : Scoreboard bench for pipe_stage_chain at DEPTH=3/WIDTH=8 and
//             DEPTH=1/WIDTH=64.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_chain;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        fl3 = 1'b0, v3 = 1'b0, or3 = 1'b0;
  logic [7:0]  d3 = '0;
  logic        ir3, ov3;
  logic [7:0]  od3;
  logic [1:0]  occ3;

  logic        fl1 = 1'b0, v1 = 1'b0, or1 = 1'b0;
  logic [63:0] d1 = '0;
  logic        ir1, ov1;
  logic [63:0] od1;
  logic [0:0]  occ1;

  int total = 0;
  int bad   = 0;

  logic [7:0]  q3[$];
  logic [63:0] q1[$];

  always #5 clk = ~clk;

  pipe_stage_chain #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .clk(clk), .reset(reset), .flush(fl3),
    .in_valid(v3), .in_data(d3), .in_ready(ir3),
    .out_valid(ov3), .out_data(od3), .out_ready(or3),
    .occupancy(occ3)
  );

  pipe_stage_chain #(.WIDTH(64), .DEPTH(1)) u_d1 (
    .clk(clk), .reset(reset), .flush(fl1),
    .in_valid(v1), .in_data(d1), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_ready(or1),
    .occupancy(occ1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Sample handshakes mid-cycle; record accepted words, compare delivered ones.
  task automatic settle();
    logic [7:0]  e8;
    logic [63:0] e64;
    @(negedge clk);
    if (ov3 && or3) begin
      if (q3.size() == 0) chk("d3_unexpected_out", {56'd0, od3}, 64'hdead);
      else begin
        e8 = q3.pop_front();
        chk("d3_out_data", {56'd0, od3}, {56'd0, e8});
      end
    end
    if (v3 && ir3) q3.push_back(d3);
    if (ov1 && or1) begin
      if (q1.size() == 0) chk("d1_unexpected_out", od1, 64'hdead);
      else begin
        e64 = q1.pop_front();
        chk("d1_out_data", od1, e64);
      end
    end
    if (v1 && ir1) q1.push_back(d1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  initial begin
    // Reset state while reset is held from time zero
    #2;
    chk("rst_out_valid", {63'd0, ov3}, 64'd0);
    chk("rst_out_data",  {56'd0, od3}, 64'd0);
    chk("rst_occ",       {62'd0, occ3}, 64'd0);
    chk("rst_in_ready",  {63'd0, ir3}, 64'd1);
    chk("rst_d1_ready",  {63'd0, ir1}, 64'd1);
    tick();
    reset = 1'b1;
    tick();

    // Mid-operation reset
    or3 = 1'b0;
    v3 = 1'b1; d3 = 8'h11; step();
    v3 = 1'b1; d3 = 8'h22; step();
    v3 = 1'b0;
    chk("pre_rst_occ", {62'd0, occ3}, 64'd2);
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, ov3}, 64'd0);
    chk("arst_out_data",  {56'd0, od3}, 64'd0);
    chk("arst_occ",       {62'd0, occ3}, 64'd0);
    q3.delete();
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_ready", {63'd0, ir3}, 64'd1);

    // Streaming: push in cycles 0-3, outputs in cycles 3-6
    or3 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v3 = (i < 4);
      d3 = 8'h11 * 8'(i + 1);
      settle();
      chk($sformatf("stream_valid_c%0d", i), {63'd0, ov3}, {63'd0, (i >= 3 && i <= 6)});
      if (i < 4) chk("stream_ready", {63'd0, ir3}, 64'd1);
      tick();
    end
    v3 = 1'b0;

    // Backpressure
    or3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v3 = 1'b1; d3 = 8'hA1 + 8'(i);
      settle();
      if (i == 3) chk("bp_ready_full", {63'd0, ir3}, 64'd0);
      tick();
    end
    chk("bp_occ", {62'd0, occ3}, 64'd3);
    settle();
    chk("bp_hold_ready", {63'd0, ir3}, 64'd0);
    tick();
    or3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("bp_drain_valid_%0d", i), {63'd0, ov3}, 64'd1);
      if (i == 0) chk("bp_popush_ready", {63'd0, ir3}, 64'd1);
      tick();
      v3 = 1'b0;
    end
    for (int i = 0; i < 2; i++) step();
    chk("bp_empty_q", 64'(q3.size()), 64'd0);

    // Bubble collapse while stalled
    or3 = 1'b0;
    v3 = 1'b1; d3 = 8'h55; step();
    v3 = 1'b0;             step();
    v3 = 1'b1; d3 = 8'h66; step();
    v3 = 1'b0;
    settle();
    chk("bub_occ",   {62'd0, occ3}, 64'd2);
    chk("bub_ready", {63'd0, ir3}, 64'd1);
    tick();
    or3 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk($sformatf("bub_out_valid_%0d", i), {63'd0, ov3}, 64'd1);
      tick();
    end
    step();
    chk("bub_empty_q", 64'(q3.size()), 64'd0);

    // Flush a full chain with a simultaneous offered word
    or3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v3 = 1'b1; d3 = 8'h01 + 8'(i); step();
    end
    chk("fl_full_occ", {62'd0, occ3}, 64'd3);
    fl3 = 1'b1; v3 = 1'b1; d3 = 8'h77; or3 = 1'b1;
    settle();
    chk("fl_in_ready",  {63'd0, ir3}, 64'd0);
    chk("fl_out_valid", {63'd0, ov3}, 64'd0);
    tick();
    q3.delete();
    fl3 = 1'b0; v3 = 1'b0;
    chk("fl_occ",      {62'd0, occ3}, 64'd0);
    chk("fl_out_data", {56'd0, od3}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("fl_no_77", {63'd0, ov3}, 64'd0);
      tick();
    end

    // Degenerate depth: full single stage, same-cycle pop/push
    or1 = 1'b0;
    v1 = 1'b1; d1 = 64'h1111_1111; step();
    chk("d1_full_occ",   {63'd0, occ1}, 64'd1);
    v1 = 1'b1; d1 = 64'h2222_2222; or1 = 1'b1;
    settle();
    chk("d1_popush_ready", {63'd0, ir1}, 64'd1);
    chk("d1_popush_valid", {63'd0, ov1}, 64'd1);
    tick();
    v1 = 1'b0; or1 = 1'b0;
    chk("d1_next_data",  od1, 64'h2222_2222);
    chk("d1_next_occ",   {63'd0, occ1}, 64'd1);
    chk("d1_next_valid", {63'd0, ov1}, 64'd1);
    or1 = 1'b1;
    step();
    chk("d1_drained_occ", {63'd0, occ1}, 64'd0);
    chk("d1_empty_q", 64'(q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
